bus_sequencer: RTL and testbench

Microcode-style control FSM that drives the register-out enables feeding the 32-bit bus multiplexer and the matching register-in strobes. It fetches one instruction from memory, then executes one register-register ALU instruction as a fixed T-state sequence. It sits between the memory handshake and the datapath; its `*out` outputs go straight into the bus select encoder.

---
 rtl/bus_sequencer_if.sv | 48 ++++
 rtl/bus_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_bus_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_sequencer_if.sv
// Bus handshake and control bundle between the instruction sequencer and the datapath.
// The master side is the sequencer. The slave side is the datapath or memory that drives start, IR and mem_ready.
interface bus_sequencer_if #(
    parameter int wordSize = 32
);
    logic                start;
    logic [wordSize-1:0] IR;
    logic                mem_ready;

    logic [15:0]         Rout;
    logic                HIout;
    logic                LOout;
    logic                Zhighout;
    logic                Zlowout;
    logic                PCout;
    logic                MDRout;

    logic [15:0]         Rin;
    logic                HIin;
    logic                LOin;
    logic                Yin;
    logic                Zin;
    logic                PCin;
    logic                IRin;
    logic                MARin;
    logic                MDRin;
    logic                IncPC;
    logic                Read;

    logic [4:0]          alu_op;
    logic                busy;
    logic                done;
    logic                illegal;

    modport master (
        input  start, IR, mem_ready,
        output Rout, HIout, LOout, Zhighout, Zlowout, PCout, MDRout,
        output Rin, HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, IncPC, Read,
        output alu_op, busy, done, illegal
    );

    modport slave (
        output start, IR, mem_ready,
        input  Rout, HIout, LOout, Zhighout, Zlowout, PCout, MDRout,
        input  Rin, HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, IncPC, Read,
        input  alu_op, busy, done, illegal
    );
endinterface

// File: rtl/bus_sequencer.sv
// Fetch plus register-register execute control FSM.
// Bus-source enables and register strobes are decoded from the state register and the IR fields.
module bus_sequencer (
    input  logic              clk,
    input  logic              clr,
    bus_sequencer_if.master   bus
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        C_BAD,
        C_TWO,
        C_UNARY,
        C_WIDE
    } op_class_t;

    state_t    state_reg;
    op_class_t op_class;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       unused_ir_low;

    assign opcode        = bus.IR[31:27];
    assign ra            = bus.IR[26:23];
    assign rb            = bus.IR[22:19];
    assign rc            = bus.IR[18:15];
    assign unused_ir_low = ^bus.IR[14:0];

    always_comb begin
        op_class = C_BAD;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: op_class = C_TWO;
            5'b10001, 5'b10010:                     op_class = C_UNARY;
            5'b01111, 5'b10000:                     op_class = C_WIDE;
            default:                                op_class = C_BAD;
        endcase
    end

    // The opcode class steers the branch out of T3, T4 and T5. IR is held stable from T3 until DONE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (bus.start) state_reg <= S_T0;
                S_T0:    state_reg <= S_T1;
                S_T1:    if (bus.mem_ready) state_reg <= S_T2;
                S_T2:    state_reg <= S_T3;
                S_T3:    state_reg <= (op_class == C_BAD) ? S_IDLE : S_T4;
                S_T4:    state_reg <= (op_class == C_UNARY) ? S_DONE : S_T5;
                S_T5:    state_reg <= (op_class == C_WIDE) ? S_T6 : S_DONE;
                S_T6:    state_reg <= S_DONE;
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    logic        rout_en;
    logic [3:0]  rout_sel;
    logic        rin_en;
    logic [3:0]  rin_sel;
    logic        zhighout;
    logic        zlowout;
    logic        pcout;
    logic        mdrout;
    logic        hiin;
    logic        loin;
    logic        yin;
    logic        zin;
    logic        pcin;
    logic        irin;
    logic        marin;
    logic        mdrin;
    logic        incpc;
    logic        read;
    logic [4:0]  alu_op;
    logic        done;
    logic        illegal;

    always_comb begin
        rout_en  = 1'b0;
        rout_sel = 4'd0;
        rin_en   = 1'b0;
        rin_sel  = 4'd0;
        zhighout = 1'b0;
        zlowout  = 1'b0;
        pcout    = 1'b0;
        mdrout   = 1'b0;
        hiin     = 1'b0;
        loin     = 1'b0;
        yin      = 1'b0;
        zin      = 1'b0;
        pcin     = 1'b0;
        irin     = 1'b0;
        marin    = 1'b0;
        mdrin    = 1'b0;
        incpc    = 1'b0;
        read     = 1'b0;
        alu_op   = 5'd0;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_reg)
            S_T0: begin
                pcout = 1'b1;
                marin = 1'b1;
                incpc = 1'b1;
                zin   = 1'b1;
            end
            S_T1: begin
                // Incremented PC and memory data are only latched once the read completes.
                zlowout = 1'b1;
                read    = 1'b1;
                pcin    = bus.mem_ready;
                mdrin   = bus.mem_ready;
            end
            S_T2: begin
                mdrout = 1'b1;
                irin   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    C_TWO: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                        yin      = 1'b1;
                    end
                    C_UNARY: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                        zin      = 1'b1;
                        alu_op   = opcode;
                    end
                    C_WIDE: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        yin      = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_TWO: begin
                        rout_en  = 1'b1;
                        rout_sel = rc;
                        zin      = 1'b1;
                        alu_op   = opcode;
                    end
                    C_UNARY: begin
                        zlowout = 1'b1;
                        rin_en  = 1'b1;
                        rin_sel = ra;
                    end
                    C_WIDE: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                        zin      = 1'b1;
                        alu_op   = opcode;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                if (op_class == C_WIDE) begin
                    zlowout = 1'b1;
                    loin    = 1'b1;
                end else if (op_class == C_TWO) begin
                    zlowout = 1'b1;
                    rin_en  = 1'b1;
                    rin_sel = ra;
                end
            end
            S_T6: begin
                zhighout = 1'b1;
                hiin     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    logic [15:0] rout_vec;
    logic [15:0] rin_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg_select
            assign rout_vec[gi] = rout_en && (rout_sel == 4'(gi));
            assign rin_vec[gi]  = rin_en  && (rin_sel  == 4'(gi));
        end
    endgenerate

    assign bus.Rout     = rout_vec;
    assign bus.HIout    = 1'b0;
    assign bus.LOout    = 1'b0;
    assign bus.Zhighout = zhighout;
    assign bus.Zlowout  = zlowout;
    assign bus.PCout    = pcout;
    assign bus.MDRout   = mdrout;
    assign bus.Rin      = rin_vec;
    assign bus.HIin     = hiin;
    assign bus.LOin     = loin;
    assign bus.Yin      = yin;
    assign bus.Zin      = zin;
    assign bus.PCin     = pcin;
    assign bus.IRin     = irin;
    assign bus.MARin    = marin;
    assign bus.MDRin    = mdrin;
    assign bus.IncPC    = incpc;
    assign bus.Read     = read;
    assign bus.alu_op   = alu_op;
    assign bus.busy     = (state_reg != S_IDLE);
    assign bus.done     = done;
    assign bus.illegal  = illegal;
endmodule

// File: tb/tb_bus_sequencer.sv
// Randomized bench for bus_sequencer.
// Each instruction is expanded into its expected per-cycle control pattern, and the DUT is compared against that pattern every cycle.
module tb_bus_sequencer;
    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    bus_sequencer_if #(.wordSize(32)) bus();

    bus_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic [5:0]  src;   // {HIout, LOout, Zhighout, Zlowout, PCout, MDRout}
        logic [9:0]  strb;  // {HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, IncPC, Read}
        logic [4:0]  alu;
        logic [2:0]  stat;  // {busy, done, illegal}
    } obs_t;

    localparam logic [5:0] SRC_ZHI = 6'b001000;
    localparam logic [5:0] SRC_ZLO = 6'b000100;
    localparam logic [5:0] SRC_PC  = 6'b000010;
    localparam logic [5:0] SRC_MDR = 6'b000001;

    localparam logic [9:0] ST_HI   = 10'h200;
    localparam logic [9:0] ST_LO   = 10'h100;
    localparam logic [9:0] ST_Y    = 10'h080;
    localparam logic [9:0] ST_Z    = 10'h040;
    localparam logic [9:0] ST_PC   = 10'h020;
    localparam logic [9:0] ST_IR   = 10'h010;
    localparam logic [9:0] ST_MAR  = 10'h008;
    localparam logic [9:0] ST_MDR  = 10'h004;
    localparam logic [9:0] ST_INC  = 10'h002;
    localparam logic [9:0] ST_READ = 10'h001;

    localparam logic [2:0] BUSY = 3'b100;
    localparam logic [2:0] DONE = 3'b010;
    localparam logic [2:0] ILL  = 3'b001;

    obs_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   txn_id       = 0;
    int   cyc_id       = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s txn=%0d cyc=%0d got=0x%0h exp=0x%0h", tag, txn_id, cyc_id, got, exp);
        end
    endtask

    function automatic obs_t mk(input logic [15:0] rout, input logic [15:0] rin, input logic [5:0] src,
                                input logic [9:0] strb, input logic [4:0] alu, input logic [2:0] stat);
        obs_t o;
        o.rout = rout;
        o.rin  = rin;
        o.src  = src;
        o.strb = strb;
        o.alu  = alu;
        o.stat = stat;
        return o;
    endfunction

    function automatic obs_t sample_obs();
        obs_t o;
        o.rout = bus.Rout;
        o.rin  = bus.Rin;
        o.src  = {bus.HIout, bus.LOout, bus.Zhighout, bus.Zlowout, bus.PCout, bus.MDRout};
        o.strb = {bus.HIin, bus.LOin, bus.Yin, bus.Zin, bus.PCin, bus.IRin,
                  bus.MARin, bus.MDRin, bus.IncPC, bus.Read};
        o.alu  = bus.alu_op;
        o.stat = {bus.busy, bus.done, bus.illegal};
        return o;
    endfunction

    task automatic check_obs(input obs_t e);
        obs_t g;
        g = sample_obs();
        check_val("rout", 32'(g.rout), 32'(e.rout));
        check_val("rin",  32'(g.rin),  32'(e.rin));
        check_val("src",  32'(g.src),  32'(e.src));
        check_val("strb", 32'(g.strb), 32'(e.strb));
        check_val("alu",  32'(g.alu),  32'(e.alu));
        check_val("stat", 32'(g.stat), 32'(e.stat));
        check_val("src_onehot", 32'($countones({g.rout, g.src}) <= 1), 32'd1);
        check_val("rin_onehot", 32'($countones(g.rin) <= 1), 32'd1);
    endtask

    // 0 = unsupported, 1 = two-operand, 2 = unary, 3 = wide result
    function automatic int op_class(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 1;
        if (op == 5'd17 || op == 5'd18) return 2;
        if (op == 5'd15 || op == 5'd16) return 3;
        return 0;
    endfunction

    // Cycle 0 is the IDLE cycle in which start is raised. The list ends at the done or illegal cycle.
    task automatic build_expected(input logic [31:0] instr, input int w);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back(mk(16'h0, 16'h0, SRC_PC, ST_MAR | ST_INC | ST_Z, 5'd0, BUSY));
        for (int k = 0; k < w; k++)
            exp_q.push_back(mk(16'h0, 16'h0, SRC_ZLO, ST_READ, 5'd0, BUSY));
        exp_q.push_back(mk(16'h0, 16'h0, SRC_ZLO, ST_READ | ST_PC | ST_MDR, 5'd0, BUSY));
        exp_q.push_back(mk(16'h0, 16'h0, SRC_MDR, ST_IR, 5'd0, BUSY));
        case (op_class(op))
            1: begin
                exp_q.push_back(mk(16'h1 << rb, 16'h0, 6'h0, ST_Y, 5'd0, BUSY));
                exp_q.push_back(mk(16'h1 << rc, 16'h0, 6'h0, ST_Z, op, BUSY));
                exp_q.push_back(mk(16'h0, 16'h1 << ra, SRC_ZLO, 10'h0, 5'd0, BUSY));
                exp_q.push_back(mk(16'h0, 16'h0, 6'h0, 10'h0, 5'd0, BUSY | DONE));
            end
            2: begin
                exp_q.push_back(mk(16'h1 << rb, 16'h0, 6'h0, ST_Z, op, BUSY));
                exp_q.push_back(mk(16'h0, 16'h1 << ra, SRC_ZLO, 10'h0, 5'd0, BUSY));
                exp_q.push_back(mk(16'h0, 16'h0, 6'h0, 10'h0, 5'd0, BUSY | DONE));
            end
            3: begin
                exp_q.push_back(mk(16'h1 << ra, 16'h0, 6'h0, ST_Y, 5'd0, BUSY));
                exp_q.push_back(mk(16'h1 << rb, 16'h0, 6'h0, ST_Z, op, BUSY));
                exp_q.push_back(mk(16'h0, 16'h0, SRC_ZLO, ST_LO, 5'd0, BUSY));
                exp_q.push_back(mk(16'h0, 16'h0, SRC_ZHI, ST_HI, 5'd0, BUSY));
                exp_q.push_back(mk(16'h0, 16'h0, 6'h0, 10'h0, 5'd0, BUSY | DONE));
            end
            default: exp_q.push_back(mk(16'h0, 16'h0, 6'h0, 10'h0, 5'd0, BUSY | ILL));
        endcase
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        logic [14:0] junk;
        junk = 15'($urandom);
        return {op, ra, rb, rc, junk};
    endfunction

    // Entered and left at one time unit after a rising edge.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_id        = -1;
            bus.start     = 1'b0;
            bus.IR        = $urandom;
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_obs('0);
            @(posedge clk);
            #1;
        end
    endtask

    // abort_at >= 0 pulls clr low in the middle of that cycle.
    task automatic run_txn(input logic [31:0] instr, input int w, input bit hold_start, input int abort_at);
        txn_id++;
        $display("[TB] txn %0d ir=0x%08h op=%b w=%0d hold=%0d abort=%0d",
                 txn_id, instr, instr[31:27], w, hold_start, abort_at);
        build_expected(instr, w);
        for (int i = 0; i < exp_q.size(); i++) begin
            cyc_id    = i;
            bus.start = (i == 0) ? 1'b1 : (hold_start ? 1'b1 : 1'($urandom_range(0, 1)));
            bus.IR    = (i < 4 + w) ? $urandom : instr;
            if (i >= 2 && i <= 2 + w)
                bus.mem_ready = (i == 2 + w);
            else
                bus.mem_ready = 1'($urandom_range(0, 1));
            if (i == abort_at) begin
                #2;
                clr = 1'b0;
                #1;
                check_obs('0);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check_obs('0);
                    @(posedge clk);
                    #1;
                end
                clr       = 1'b1;
                bus.start = 1'b0;
                break;
            end
            @(negedge clk);
            check_obs(exp_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    logic [4:0] legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                   5'd15, 5'd16, 5'd17, 5'd18};

    initial begin
        clr           = 1'b0;
        bus.start     = 1'b1;
        bus.IR        = $urandom;
        bus.mem_ready = 1'b1;
        cyc_id        = -1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_obs('0);
        end
        @(posedge clk);
        #1;
        clr       = 1'b1;
        bus.start = 1'b0;
        idle_cycles(2);

        run_txn(32'h18A10000, 0, 1'b0, -1);
        run_txn(mk_ir(5'b00100, 4'd9, 4'd2, 4'd13), 2, 1'b0, -1);
        run_txn(mk_ir(5'b01111, 4'd3, 4'd5, 4'd0), 0, 1'b0, -1);
        run_txn(mk_ir(5'b10001, 4'd7, 4'd6, 4'd1), 0, 1'b0, -1);
        run_txn(mk_ir(5'b11111, 4'd2, 4'd3, 4'd4), 0, 1'b0, -1);
        idle_cycles(1);
        run_txn(mk_ir(5'b00101, 4'd5, 4'd5, 4'd5), 1, 1'b1, -1);
        run_txn(mk_ir(5'b10000, 4'd15, 4'd0, 4'd8), 3, 1'b1, -1);
        idle_cycles(1);
        run_txn(32'h18A10000, 0, 1'b0, 5);
        run_txn(32'h18A10000, 0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            logic [4:0] op;
            if ($urandom_range(0, 3) == 0)
                op = 5'($urandom);
            else
                op = legal_ops[$urandom_range(0, 12)];
            run_txn(mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
            idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
